// File: rtl/sipo_deserializer.sv
// rtl/sipo_deserializer.sv - serial-in/parallel-out word assembler with one-word holding register
//
// Assembles WIDTH-bit words LSB-first from a d_valid-qualified serial bit and
// presents them on a valid/ready interface. A completed word that arrives while
// the holding register is still occupied is dropped and flagged on overrun.
//
// Optional feature macro: SIPO_PARITY_EN
//   defined   : one extra d_valid bit after the data bits carries even parity;
//               the word completes on that bit and parity_err reports the check.
//   undefined : the word completes on its WIDTH-th bit; parity_err is tied to 0.
//
// Ports:
//   clk         in   1      rising-edge clock
//   rst         in   1      synchronous reset, active-high
//   d           in   1      serial data bit
//   d_valid     in   1      d is sampled on every edge where d_valid=1
//   p_data      out  WIDTH  assembled word, first received bit in p_data[0]
//   p_valid     out  1      p_data holds an unconsumed word
//   p_ready     in   1      consumer takes the word when p_valid & p_ready
//   overrun     out  1      one-cycle pulse: a completed word was dropped
//   parity_err  out  1      parity result for the word in p_data

module sipo_deserializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d,
  input  logic             d_valid,
  output logic [WIDTH-1:0] p_data,
  output logic             p_valid,
  input  logic             p_ready,
  output logic             overrun,
  output logic             parity_err
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic             complete;
  logic [WIDTH-1:0] word;

`ifdef SIPO_PARITY_EN
  typedef enum logic {COLLECT, PARITY} state_t;
  state_t state_q, state_d;
  logic   perr_q, perr_d;
  logic   word_perr;
`endif

  always_comb begin
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    complete = 1'b0;
    word     = sr_q;
`ifdef SIPO_PARITY_EN
    state_d   = state_q;
    word_perr = 1'b0;
    if (d_valid) begin
      if (state_q == PARITY) begin
        // Data bits are already fully shifted in; this bit is only the parity.
        complete  = 1'b1;
        word      = sr_q;
        word_perr = (^sr_q) ^ d;
        state_d   = COLLECT;
      end else begin
        sr_d = {d, sr_q[WIDTH-1:1]};
        if (cnt_q == CW'(WIDTH - 1)) begin
          cnt_d   = '0;
          state_d = PARITY;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end
`else
    if (d_valid) begin
      sr_d = {d, sr_q[WIDTH-1:1]};
      if (cnt_q == CW'(WIDTH - 1)) begin
        cnt_d    = '0;
        complete = 1'b1;
        word     = {d, sr_q[WIDTH-1:1]};
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
`endif

    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
`ifdef SIPO_PARITY_EN
    perr_d  = perr_q;
`endif
    if (complete) begin
      // Holding register is free if empty or being drained this same cycle.
      if (!valid_q || p_ready) begin
        data_d  = word;
        valid_d = 1'b1;
`ifdef SIPO_PARITY_EN
        perr_d  = word_perr;
`endif
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && p_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q    <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef SIPO_PARITY_EN
      state_q <= COLLECT;
      perr_q  <= 1'b0;
`endif
    end else begin
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
`ifdef SIPO_PARITY_EN
      state_q <= state_d;
      perr_q  <= perr_d;
`endif
    end
  end

  assign p_data  = data_q;
  assign p_valid = valid_q;
  assign overrun = ovr_q;
`ifdef SIPO_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_deserializer.sv
// tb/tb_sipo_deserializer.sv - self-checking bench for sipo_deserializer
module tb_sipo_deserializer;

  localparam int WIDTH = 8;
`ifdef SIPO_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             d = 1'b0;
  logic             d_valid = 1'b0;
  logic [WIDTH-1:0] p_data;
  logic             p_valid;
  logic             p_ready = 1'b0;
  logic             overrun;
  logic             parity_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: frame bit position, accumulated word, expected outputs.
  int               m_nbits = 0;
  logic [WIDTH-1:0] m_acc   = '0;
  logic [WIDTH-1:0] m_data  = '0;
  logic             m_valid = 1'b0;
  logic             m_ovr   = 1'b0;
  logic             m_perr  = 1'b0;

  sipo_deserializer #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .d          (d),
    .d_valid    (d_valid),
    .p_data     (p_data),
    .p_valid    (p_valid),
    .p_ready    (p_ready),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  // Drive one cycle, wait past the edge, then advance the reference model.
  task automatic cycle(input logic bd, input logic bv, input logic br, input logic brst);
    logic             done;
    logic [WIDTH-1:0] w;
    logic             pe;
    d = bd; d_valid = bv; p_ready = br; rst = brst;
    @(posedge clk);
    #1;
    done = 1'b0; w = '0; pe = 1'b0;
    if (brst) begin
      m_nbits = 0; m_acc = '0; m_data = '0; m_valid = 1'b0; m_ovr = 1'b0; m_perr = 1'b0;
    end else begin
      if (bv) begin
        if (m_nbits < WIDTH) begin
          m_acc[m_nbits] = bd;
          m_nbits++;
          if (PAR == 0 && m_nbits == WIDTH) begin
            done = 1'b1; w = m_acc; pe = 1'b0;
            m_nbits = 0; m_acc = '0;
          end
        end else begin
          done = 1'b1; w = m_acc;
          pe = (($countones(m_acc) + int'(bd)) % 2) != 0;
          m_nbits = 0; m_acc = '0;
        end
      end
      m_ovr = 1'b0;
      if (done) begin
        if (!m_valid || br) begin
          m_data = w; m_valid = 1'b1; m_perr = pe;
        end else begin
          m_ovr = 1'b1;
        end
      end else if (m_valid && br) begin
        m_valid = 1'b0;
      end
    end
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w, input logic pb, input logic rdy_body,
                           input logic rdy_last, input int maxgap);
    logic b;
    logic last;
    for (int i = 0; i < WIDTH + PAR; i++) begin
      last = (i == WIDTH + PAR - 1);
      b    = (i < WIDTH) ? w[i] : pb;
      if (maxgap > 0) repeat ($urandom_range(maxgap, 1)) cycle(1'($urandom), 1'b0, rdy_body, 1'b0);
      cycle(b, 1'b1, last ? rdy_last : rdy_body, 1'b0);
    end
  endtask

  task automatic test_reset;
    cycle(1'b1, 1'b1, 1'b1, 1'b1);
    n_checks++;
    if ({p_data, p_valid, overrun, parity_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got data=%h v=%b o=%b pe=%b, want all 0", p_data, p_valid, overrun, parity_err);
    end
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_basic;
    send_word(8'hA5, 1'b0, 1'b1, 1'b1, 0);
    n_checks++;
    if ({p_data, p_valid, overrun} !== {8'hA5, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL basic_word: got data=%h v=%b o=%b, want A5 1 0", p_data, p_valid, overrun);
    end
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (p_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_consumed: got v=%b, want 0", p_valid);
    end
  endtask

  task automatic test_gaps;
    logic [WIDTH-1:0] w;
    logic             b;
    int               early;
    w = 8'hA5;
    early = 0;
    for (int i = 0; i < WIDTH + PAR; i++) begin
      b = (i < WIDTH) ? w[i] : (^w);
      repeat ($urandom_range(3, 1)) cycle(1'($urandom), 1'b0, 1'b1, 1'b0);
      cycle(b, 1'b1, 1'b1, 1'b0);
      if (i < WIDTH + PAR - 1 && p_valid !== 1'b0) early++;
    end
    n_checks++;
    if (early != 0) begin
      n_fail++;
      $display("FAIL gaps_early_valid: got %0d early valid cycles, want 0", early);
    end
    n_checks++;
    if ({p_data, p_valid, overrun} !== {8'hA5, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL gaps_word: got data=%h v=%b o=%b, want A5 1 0", p_data, p_valid, overrun);
    end
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_overrun;
    send_word(8'h3C, ^8'h3C, 1'b0, 1'b0, 0);
    n_checks++;
    if ({p_data, p_valid} !== {8'h3C, 1'b1}) begin
      n_fail++;
      $display("FAIL ovr_first: got data=%h v=%b, want 3C 1", p_data, p_valid);
    end
    send_word(8'hC3, ^8'hC3, 1'b0, 1'b0, 0);
    n_checks++;
    if ({p_data, p_valid, overrun} !== {8'h3C, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL ovr_pulse: got data=%h v=%b o=%b, want 3C 1 1", p_data, p_valid, overrun);
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if ({p_data, p_valid, overrun} !== {8'h3C, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL ovr_one_cycle: got data=%h v=%b o=%b, want 3C 1 0", p_data, p_valid, overrun);
    end
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (p_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_drain: got v=%b, want 0", p_valid);
    end
  endtask

  task automatic test_back_to_back;
    send_word(8'h11, ^8'h11, 1'b1, 1'b1, 0);
    n_checks++;
    if ({p_data, p_valid} !== {8'h11, 1'b1}) begin
      n_fail++;
      $display("FAIL b2b_first: got data=%h v=%b, want 11 1", p_data, p_valid);
    end
    send_word(8'h22, ^8'h22, 1'b0, 1'b1, 0);
    n_checks++;
    if ({p_data, p_valid, overrun} !== {8'h22, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL b2b_accept_load: got data=%h v=%b o=%b, want 22 1 0", p_data, p_valid, overrun);
    end
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid;
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b1);
    n_checks++;
    if ({p_data, p_valid, overrun, parity_err} !== '0) begin
      n_fail++;
      $display("FAIL midrst_outputs: got data=%h v=%b o=%b pe=%b, want all 0", p_data, p_valid, overrun, parity_err);
    end
    send_word(8'h3C, ^8'h3C, 1'b1, 1'b1, 0);
    n_checks++;
    if ({p_data, p_valid} !== {8'h3C, 1'b1}) begin
      n_fail++;
      $display("FAIL midrst_word: got data=%h v=%b, want 3C 1", p_data, p_valid);
    end
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_parity;
    logic [WIDTH-1:0] w;
    w = 8'hA5;
`ifdef SIPO_PARITY_EN
    for (int pb = 0; pb < 2; pb++) begin
      for (int i = 0; i < WIDTH; i++) cycle(w[i], 1'b1, 1'b1, 1'b0);
      n_checks++;
      if (p_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL par_valid_early: got v=%b after data bits, want 0", p_valid);
      end
      cycle(1'(pb), 1'b1, 1'b1, 1'b0);
      n_checks++;
      if ({p_data, p_valid, parity_err} !== {8'hA5, 1'b1, 1'(pb)}) begin
        n_fail++;
        $display("FAIL par_result: got data=%h v=%b pe=%b, want A5 1 %0d", p_data, p_valid, parity_err, pb);
      end
      cycle(1'b0, 1'b0, 1'b1, 1'b0);
    end
`else
    w = 8'hA4;
    send_word(w, 1'b1, 1'b1, 1'b1, 0);
    n_checks++;
    if ({p_data, p_valid, parity_err} !== {8'hA4, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL par_disabled: got data=%h v=%b pe=%b, want A4 1 0", p_data, p_valid, parity_err);
    end
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
`endif
  endtask

  task automatic test_random;
    int bad;
    bad = 0;
    for (int k = 0; k < 3000; k++) begin
      cycle(1'($urandom), ($urandom_range(9, 0) < 7), 1'($urandom), ($urandom_range(199, 0) == 0));
      n_checks++;
      if ({p_data, p_valid, overrun, parity_err} !== {m_data, m_valid, m_ovr, m_perr}) begin
        n_fail++;
        if (bad < 10)
          $display("FAIL random_cycle%0d: got data=%h v=%b o=%b pe=%b, want data=%h v=%b o=%b pe=%b",
                   k, p_data, p_valid, overrun, parity_err, m_data, m_valid, m_ovr, m_perr);
        bad++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    test_parity();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
